// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, keyboard command bytes and
// the odd-parity / frame helpers used by the transmitter.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      START,
      SEND,
      ACK,
      WAIT_IDLE
   } ps2_state_e;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ECHO     = 8'hEE;
   localparam logic [7:0] CMD_RESET    = 8'hFF;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   // LSB first on the wire: start(0), d0..d7, parity, stop(1).
   function automatic logic [10:0] make_frame(input logic [7:0] d);
      return {1'b1, odd_parity(d), d, 1'b0};
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer plus falling-edge detect for the PS/2 clock and data lines.
// Sync outputs lag the raw line by 2 clk; a fall pulse is one cycle wide.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic clk_sync_o,
   output logic data_sync_o,
   output logic clk_fall_o,
   output logic data_fall_o
);

   // [0],[1] synchronize; [2] is the previous synchronized value.
   logic [2:0] clk_sh_q;
   logic [2:0] data_sh_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sh_q  <= '1;
         data_sh_q <= '1;
      end else begin
         clk_sh_q  <= {clk_sh_q[1:0], ps2_clk_i};
         data_sh_q <= {data_sh_q[1:0], ps2_data_i};
      end
   end

   assign clk_sync_o  = clk_sh_q[1];
   assign data_sync_o = data_sh_q[1];
   assign clk_fall_o  = clk_sh_q[2] & ~clk_sh_q[1];
   assign data_fall_o = data_sh_q[2] & ~data_sh_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 10 device-clocked bits, ACK check.
// Define PS2_TX_WATCHDOG_EN to abort with err when the device stops clocking.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 12_000,
   parameter int TIMEOUT_CYCLES = 200_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int CNT_W = $clog2(INHIBIT_CYCLES + 1);

   if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 2");
   end

   ps2_state_e       state_q, state_d;
   logic [10:0]      frame_q, frame_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic             ack_q, ack_d;
   logic             tx_ready_q, tx_ready_d;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic clk_sync, data_sync, clk_fall, data_fall_unused;
   logic timeout;

   ps2_line_sync u_sync (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk_i   (ps2_clk_in),
      .ps2_data_i  (ps2_data_in),
      .clk_sync_o  (clk_sync),
      .data_sync_o (data_sync),
      .clk_fall_o  (clk_fall),
      .data_fall_o (data_fall_unused)
   );

`ifdef PS2_TX_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q;
   logic            wd_armed;

   assign wd_armed = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);

   always_ff @(posedge clk) begin
      if (rst || clk_fall || (state_d != state_q)) begin
         wd_q <= '0;
      end else if (wd_armed) begin
         wd_q <= wd_q + 1'b1;
      end
   end

   assign timeout = wd_armed && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      ack_d     = ack_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (tx_valid && tx_ready_q) begin
               frame_d  = make_frame(tx_data);
               cnt_d    = '0;
               busy_d   = 1'b1;
               clk_oe_d = 1'b1;
               state_d  = INHIBIT;
            end
         end
         INHIBIT: begin
            // Device clock edges here are our own inhibit pulse or contention: ignored.
            if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
               data_oe_d = ~frame_q[0];
               state_d   = START;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         START: begin
            clk_oe_d  = 1'b0;
            frame_d   = {1'b0, frame_q[10:1]};
            bit_cnt_d = '0;
            state_d   = SEND;
         end
         SEND: begin
            if (clk_fall) begin
               data_oe_d = ~frame_q[0];
               frame_d   = {1'b0, frame_q[10:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd9) begin
                  state_d = ACK;
               end
            end
         end
         ACK: begin
            if (clk_fall) begin
               ack_d   = ~data_sync;
               state_d = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
               done_d  = ack_q;
               err_d   = ~ack_q;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (timeout) begin
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
         busy_d    = 1'b0;
         done_d    = 1'b0;
         err_d     = 1'b1;
         state_d   = IDLE;
      end

      tx_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         frame_q    <= '0;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         ack_q      <= 1'b0;
         tx_ready_q <= 1'b0;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         ack_q      <= ack_d;
         tx_ready_q <= tx_ready_d;
         clk_oe_q   <= clk_oe_d;
         data_oe_q  <= data_oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign tx_ready    = tx_ready_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a keyboard model clocks each frame and records the bits it sees;
// expected frames come from the byte via plain bit arithmetic, invariants are checked every cycle.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 200;   // scaled-down inhibit time
   localparam int TO   = 1000;
   localparam int HALF = 20;    // device half clock period in clk cycles

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       ps2_clk_in, ps2_data_in;

   // Open-drain wired-AND of host and device pull-downs.
   assign ps2_clk_in  = !(ps2_clk_oe === 1'b1 || dev_clk_low);
   assign ps2_data_in = !(ps2_data_oe === 1'b1 || dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   int  n_checks = 0;
   int  n_pass = 0;
   int  done_cnt = 0, err_cnt = 0, acc_cnt = 0, inh_cnt = 0, cloe_cnt = 0;
   bit  mon_en = 1'b0;
   logic prev_busy = 1'b0;
   time last_fall_t = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Expected wire bits d0..d7, parity, stop for a byte.
   function automatic logic [9:0] model_frame(input logic [7:0] d);
      logic p;
      p = ($countones(d) % 2 == 0);
      return {1'b1, p, d};
   endfunction

   // Per-cycle monitor: counters plus handshake/pulse invariants.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && mon_en) begin
            chk("ready_is_not_busy", tx_ready, !busy);
            chk("clk_oe_only_while_busy", ps2_clk_oe && !busy, 1'b0);
            chk("done_err_exclusive", done && err, 1'b0);
            if (done || err) chk("pulse_with_busy_fall", {prev_busy, busy}, 2'b10);
         end
         if (done) done_cnt++;
         if (err) err_cnt++;
         if (!rst && tx_valid && tx_ready) acc_cnt++;
         if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
         if (ps2_clk_oe) cloe_cnt++;
         prev_busy = busy;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 5 ms");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_tx(input logic [7:0] d, input bit hold);
      @(posedge clk); #1;
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid = hold;
   endtask

   task automatic wait_busy_low(input int limit);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (busy !== 1'b0 && t < limit);
      chk("busy_low_within_bound", t < limit, 1'b1);
   endtask

   // Keyboard model: clocks out a frame, sampling data on each rising clock.
   // stop_after>0 abandons the frame after that many falls with both lines released.
   task automatic dev_frame(input int stop_after, input bit nack, output logic [9:0] got);
      int t;
      got = '0;
      t = 0;
      do begin
         tick(1);
         t++;
      end while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && t < INH + 200);
      chk("start_condition_seen", t < INH + 200, 1'b1);
      if (t >= INH + 200) return;
      tick(HALF);
      for (int k = 1; k <= 11; k++) begin
         if (k == 11 && !nack) begin
            dev_data_low = 1'b1;
            tick(4);
         end
         dev_clk_low = 1'b1;
         last_fall_t = $time;
         tick(HALF);
         dev_clk_low = 1'b0;
         if (k <= 10) got[k-1] = ps2_data_in;
         if (k == stop_after) return;
         tick(HALF);
      end
      dev_data_low = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] d, input bit nack, output logic [9:0] got);
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(d, 1'b0);
      dev_frame(0, nack, got);
      wait_busy_low(200);
      @(negedge clk);
      chk("frame_bits", got, model_frame(d));
      chk("odd_parity", $countones(got[8:0]) % 2, 1);
      chk("done_pulses", done_cnt - d0, nack ? 0 : 1);
      chk("err_pulses", err_cnt - e0, nack ? 1 : 0);
      chk("ready_after_frame", tx_ready, 1'b1);
   endtask

   logic [9:0] got;
   int d0, e0, a0;

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err}, 6'b0);
      @(posedge clk); #1 rst = 1'b0;
      tick(1);
      @(negedge clk);
      chk("ready_after_reset", tx_ready, 1'b1);
      chk("busy_after_reset", busy, 1'b0);
      mon_en = 1'b1;

      // 0xED with ACK; inhibit timing
      inh_cnt  = 0;
      cloe_cnt = 0;
      run_frame(CMD_SET_LEDS, 1'b0, got);
      chk("ed_literal", got, 10'h3ED);
      chk("clk_inhibit_before_start", inh_cnt, INH);
      chk("clk_oe_total_cycles", cloe_cnt, INH + 1);

      // Parity corner bytes
      run_frame(8'h07, 1'b0, got);
      chk("h07_literal", got, 10'h207);
      run_frame(8'h00, 1'b0, got);
      chk("h00_literal", got, 10'h300);

      // NACK
      run_frame(CMD_RESET, 1'b1, got);
      chk("ff_literal", got, 10'h3FF);

      // tx_valid held through a frame
      a0 = acc_cnt;
      d0 = done_cnt;
      start_tx(CMD_ECHO, 1'b1);
      dev_frame(0, 1'b0, got);
      chk("ee_frame_bits", got, model_frame(CMD_ECHO));
      chk("one_accept_during_frame", acc_cnt - a0, 1);
      wait_busy_low(200);
      @(posedge clk); #1 tx_valid = 1'b0;
      @(negedge clk);
      chk("reaccept_after_done", busy, 1'b1);
      chk("two_accepts_total", acc_cnt - a0, 2);
      chk("first_done_seen", done_cnt - d0, 1);
      dev_frame(0, 1'b0, got);
      wait_busy_low(200);
      @(negedge clk);
      chk("ee_second_frame_bits", got, model_frame(CMD_ECHO));
      chk("ee_done_pulses", done_cnt - d0, 2);

      // Reset at bit 4
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(CMD_SET_LEDS, 1'b0);
      dev_frame(4, 1'b0, got);
      chk("busy_before_midreset", busy, 1'b1);
      mon_en = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midreset_released", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
      tick(1);
      mon_en = 1'b1;
      tick(5);
      chk("midreset_no_done", done_cnt - d0, 0);
      chk("midreset_no_err", err_cnt - e0, 0);
      run_frame(CMD_SET_LEDS, 1'b0, got);

      // Device stops clocking after bit 3
      e0 = err_cnt;
      start_tx(8'h5A, 1'b0);
      dev_frame(3, 1'b0, got);
`ifdef PS2_TX_WATCHDOG_EN
      begin
         int t;
         int gap;
         t = 0;
         while (err !== 1'b1 && t < TO + 100) begin
            @(negedge clk);
            t++;
         end
         gap = int'(($time - last_fall_t) / 10);
         chk("watchdog_err_seen", err, 1'b1);
         chk("watchdog_gap_in_window", (gap >= TO) && (gap <= TO + 5), 1'b1);
         chk("watchdog_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
         chk("watchdog_busy_cleared", busy, 1'b0);
         tick(2);
      end
`else
      tick(2 * TO);
      @(negedge clk);
      chk("stall_still_busy", busy, 1'b1);
      chk("stall_no_err", err_cnt - e0, 0);
      chk("stall_clk_released", ps2_clk_oe, 1'b0);
      mon_en = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      tick(1);
      mon_en = 1'b1;
`endif

      // Recovery frame
      run_frame(CMD_ECHO, 1'b0, got);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
